program_fetch: RTL and testbench
================================

PROGRAM_FETCH -- requirements
Module: program_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h01: first address fetched after start.
REQ-002 Parameter END_PC, default 8'h03: last address fetched before the block stops.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins fetching; honoured only in IDLE.
REQ-006 PC_Address  output  8  address driven to the instruction memory; registered output.
REQ-007 instr_in  input  8  memory read data for the current PC_Address; combinational, valid in the same cycle.
REQ-008 instr_out  output  8  registered instruction presented to decode.
REQ-009 instr_pc  output  8  address from which instr_out was fetched.
REQ-010 instr_valid  output  1  instr_out/instr_pc hold a valid instruction.
REQ-011 instr_ready  input  1  decode accepts the instruction; a transfer occurs on a cycle with instr_valid=1 and instr_ready=1.
REQ-012 branch_valid  input  1  redirect request, sampled each cycle.
REQ-013 branch_target  input  8  redirect address, qualified by branch_valid.
REQ-014 done  output  1  high in state DONE.
REQ-015 fetch_count  output  8  number of accepted transfers since reset; saturating.

Function
REQ-016 The FSM SHALL have four states: IDLE, FETCH, HOLD and DONE.
REQ-017 In IDLE, start=1 SHALL load PC_Address<=RESET_PC and move to FETCH; all other inputs except reset are ignored.
REQ-018 Slot free is defined as instr_valid=0 or instr_ready=1.
REQ-019 In FETCH with the slot free, the block SHALL capture instr_in->instr_out and PC_Address->instr_pc and set instr_valid=1, all in the same cycle.
REQ-020 On that capture, PC_Address SHALL advance by 1, wrapping modulo 256 (8'hFF->8'h00).
REQ-021 In FETCH with the slot not free, the block SHALL go to HOLD, holding PC_Address, instr_out, instr_pc and instr_valid stable.
REQ-022 In HOLD, instr_ready=1 SHALL return the FSM to FETCH; during that cycle instr_valid drops to 0 with no capture.
REQ-023 A capture of PC_Address==END_PC SHALL move the FSM to DONE with PC_Address unchanged; the captured word stays valid until accepted.
REQ-024 In DONE, no further capture SHALL occur; a transfer clears instr_valid; done=1.
REQ-025 branch_valid=1 in FETCH, HOLD or DONE SHALL clear instr_valid, load PC_Address<=branch_target and enter FETCH. It takes priority over capture, transfer and the END_PC check.
REQ-026 branch_valid SHALL be ignored in IDLE.
REQ-027 fetch_count SHALL increment on every transfer, including one coinciding with a branch, and saturate at 8'hFF.
REQ-028 Latency from a PC_Address value to its instr_out/instr_valid SHALL be 1 clock; throughput SHALL be 1 instruction per clock while instr_ready=1.

Reset
REQ-029 reset=1 SHALL immediately, without a clock edge, force state=IDLE, PC_Address=RESET_PC, instr_out=8'h00, instr_pc=8'h00, instr_valid=0, done=0 and fetch_count=8'h00.
REQ-030 Reset asserted mid-operation, including during HOLD or DONE, SHALL discard any pending instruction; nothing resumes until a new start.
REQ-031 The first start SHALL be honoured on the first rising edge after reset deasserts.

Verification
REQ-032 Memory image {01:30h, 02:48h, 03:81h}, instr_ready=1, start pulse -> instr_out 30h/48h/81h with instr_pc 01/02/03 on 3 consecutive cycles; done=1; fetch_count=3.
REQ-033 Same image, instr_ready=0 for 4 cycles after the first capture -> instr_out=30h and PC_Address=02 held stable, state HOLD; ready=1 -> remaining fetches resume with none lost or duplicated.
REQ-034 branch_valid=1, branch_target=8'h01 while instr_pc=02 is valid and unaccepted -> instr_valid=0 next cycle, then instr_out=30h with instr_pc=01.
REQ-035 Wrap: RESET_PC=8'hFE, END_PC=8'h01 -> fetch order FE, FF, 00, 01, then done=1.
REQ-036 Reset pulsed in HOLD with instr_valid=1 -> outputs zero asynchronously, PC_Address=RESET_PC; start then repeats the sequence from RESET_PC.
REQ-037 Saturation: 300 accepted transfers with branch_target=RESET_PC looped -> fetch_count stays at 8'hFF.

Source files
------------

// File: rtl/program_fetch.sv
// Instruction fetch stage: walks PC from RESET_PC to END_PC into a
// one-entry output slot with valid/ready handshake and branch redirect.
module program_fetch #(
  parameter logic [7:0] RESET_PC = 8'h01,
  parameter logic [7:0] END_PC   = 8'h03
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] PC_Address,
  input  logic [7:0] instr_in,
  output logic [7:0] instr_out,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       branch_valid,
  input  logic [7:0] branch_target,
  output logic       done,
  output logic [7:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } state_t;

  state_t state;

  logic xfer;
  logic slot_free;
  logic at_end;

  assign xfer      = instr_valid & instr_ready;
  assign slot_free = ~instr_valid | instr_ready;
  assign at_end    = (PC_Address == END_PC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 8'h00;
    end else if (xfer && fetch_count != 8'hFF) begin
      fetch_count <= fetch_count + 8'h01;
    end
  end

  // Branch outranks every other action once the fetch loop is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      PC_Address  <= RESET_PC;
      instr_out   <= 8'h00;
      instr_pc    <= 8'h00;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else if (state != IDLE && branch_valid) begin
      state       <= FETCH;
      PC_Address  <= branch_target;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            PC_Address <= RESET_PC;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (slot_free) begin
            instr_out   <= instr_in;
            instr_pc    <= PC_Address;
            instr_valid <= 1'b1;
            if (at_end) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              PC_Address <= PC_Address + 8'h01;
            end
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        DONE: begin
          if (xfer) begin
            instr_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_fetch.sv
// Bench for program_fetch: vector table, hand sequences and random
// stimulus compared against a behavioural model.
module tb_program_fetch;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       instr_ready = 1'b0;
  logic       branch_valid = 1'b0;
  logic [7:0] branch_target = 8'h00;

  logic [7:0] pc1, out1, ipc1, cnt1, in1;
  logic       v1, d1;
  logic [7:0] pc2, out2, ipc2, cnt2, in2;
  logic       v2, d2;

  logic [7:0] mem [256];

  assign in1 = mem[pc1];
  assign in2 = mem[pc2];

  always #5 clk = ~clk;

  program_fetch dut (
    .clk(clk), .reset(reset), .start(start),
    .PC_Address(pc1), .instr_in(in1),
    .instr_out(out1), .instr_pc(ipc1),
    .instr_valid(v1), .instr_ready(instr_ready),
    .branch_valid(branch_valid),
    .branch_target(branch_target),
    .done(d1), .fetch_count(cnt1)
  );

  program_fetch #(.RESET_PC(8'hFE), .END_PC(8'h01)) dut_wrap (
    .clk(clk), .reset(reset), .start(start),
    .PC_Address(pc2), .instr_in(in2),
    .instr_out(out2), .instr_pc(ipc2),
    .instr_valid(v2), .instr_ready(instr_ready),
    .branch_valid(branch_valid),
    .branch_target(branch_target),
    .done(d2), .fetch_count(cnt2)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a started flag, a mode, the PC, one instruction slot
  // and a saturating transfer counter, advanced by the fetch rules.
  localparam logic [7:0] M_RESET = 8'h01;
  localparam logic [7:0] M_END   = 8'h03;
  localparam int RUN = 0, STALL = 1, FIN = 2;

  bit         m_started;
  int         m_mode;
  logic [7:0] m_pc, m_word, m_wpc, m_cnt;
  bit         m_valid;

  function automatic bit m_done();
    return m_started && m_mode == FIN;
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_mode = RUN;
    m_pc = M_RESET;
    m_word = 8'h00;
    m_wpc = 8'h00;
    m_valid = 0;
    m_cnt = 8'h00;
  endtask

  task automatic model_step();
    bit took;
    took = m_valid && instr_ready;
    if (took && m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
    if (!m_started) begin
      if (start) begin
        m_started = 1;
        m_mode = RUN;
        m_pc = M_RESET;
      end
    end else if (branch_valid) begin
      m_valid = 0;
      m_pc = branch_target;
      m_mode = RUN;
    end else if (m_mode == RUN) begin
      if (!m_valid || instr_ready) begin
        m_word = mem[m_pc];
        m_wpc = m_pc;
        m_valid = 1;
        if (m_pc == M_END) m_mode = FIN;
        else m_pc = m_pc + 8'h01;
      end else begin
        m_mode = STALL;
      end
    end else if (m_mode == STALL) begin
      if (instr_ready) begin
        m_valid = 0;
        m_mode = RUN;
      end
    end else if (took) begin
      m_valid = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    branch_valid = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    bit         st;
    bit         rdy;
    bit         bv;
    logic [7:0] bt;
    logic [7:0] pc;
    logic [7:0] out;
    logic [7:0] ipc;
    bit         v;
    bit         d;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit rst, bit st, bit rdy, bit bv,
      logic [7:0] bt, logic [7:0] pc, logic [7:0] out,
      logic [7:0] ipc, bit v, bit d, logic [7:0] cnt);
    vec_t r;
    r.rst = rst; r.st = st; r.rdy = rdy; r.bv = bv; r.bt = bt;
    r.pc = pc; r.out = out; r.ipc = ipc; r.v = v; r.d = d;
    r.cnt = cnt;
    return r;
  endfunction

  initial begin
    logic [7:0] seen[$];
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h01] = 8'h30;
    mem[8'h02] = 8'h48;
    mem[8'h03] = 8'h81;
    mem[8'hFE] = 8'h11;
    mem[8'hFF] = 8'h22;
    mem[8'h00] = 8'h33;

    // straight run, ready always high
    vt.push_back(mk(1,1,1,0,0, 8'h01,8'h00,8'h00,0,0,8'd0));
    vt.push_back(mk(0,0,1,0,0, 8'h02,8'h30,8'h01,1,0,8'd0));
    vt.push_back(mk(0,0,1,0,0, 8'h03,8'h48,8'h02,1,0,8'd1));
    vt.push_back(mk(0,0,1,0,0, 8'h03,8'h81,8'h03,1,1,8'd2));
    vt.push_back(mk(0,0,1,0,0, 8'h03,8'h81,8'h03,0,1,8'd3));
    vt.push_back(mk(0,0,1,0,0, 8'h03,8'h81,8'h03,0,1,8'd3));
    // stall for four cycles after the first capture
    vt.push_back(mk(1,1,1,0,0, 8'h01,8'h00,8'h00,0,0,8'd0));
    vt.push_back(mk(0,0,0,0,0, 8'h02,8'h30,8'h01,1,0,8'd0));
    vt.push_back(mk(0,0,0,0,0, 8'h02,8'h30,8'h01,1,0,8'd0));
    vt.push_back(mk(0,0,0,0,0, 8'h02,8'h30,8'h01,1,0,8'd0));
    vt.push_back(mk(0,0,0,0,0, 8'h02,8'h30,8'h01,1,0,8'd0));
    vt.push_back(mk(0,0,0,0,0, 8'h02,8'h30,8'h01,1,0,8'd0));
    vt.push_back(mk(0,0,1,0,0, 8'h02,8'h30,8'h01,0,0,8'd1));
    vt.push_back(mk(0,0,1,0,0, 8'h03,8'h48,8'h02,1,0,8'd1));
    vt.push_back(mk(0,0,1,0,0, 8'h03,8'h81,8'h03,1,1,8'd2));
    vt.push_back(mk(0,0,1,0,0, 8'h03,8'h81,8'h03,0,1,8'd3));
    // branch back while instr_pc 02 is pending
    vt.push_back(mk(1,1,1,0,0, 8'h01,8'h00,8'h00,0,0,8'd0));
    vt.push_back(mk(0,0,1,0,0, 8'h02,8'h30,8'h01,1,0,8'd0));
    vt.push_back(mk(0,0,1,0,0, 8'h03,8'h48,8'h02,1,0,8'd1));
    vt.push_back(mk(0,0,0,1,1, 8'h01,8'h48,8'h02,0,0,8'd1));
    vt.push_back(mk(0,0,1,0,0, 8'h02,8'h30,8'h01,1,0,8'd1));

    @(negedge clk);
    do_reset();
    chk("rst.pc", pc1, 8'h01);
    chk("rst.valid", v1, 1'b0);
    chk("rst.done", d1, 1'b0);
    chk("rst.cnt", cnt1, 8'h00);

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      start = vt[i].st;
      instr_ready = vt[i].rdy;
      branch_valid = vt[i].bv;
      branch_target = vt[i].bt;
      cycle();
      chk($sformatf("vec%0d.pc", i), pc1, vt[i].pc);
      chk($sformatf("vec%0d.out", i), out1, vt[i].out);
      chk($sformatf("vec%0d.ipc", i), ipc1, vt[i].ipc);
      chk($sformatf("vec%0d.valid", i), v1, vt[i].v);
      chk($sformatf("vec%0d.done", i), d1, vt[i].d);
      chk($sformatf("vec%0d.cnt", i), cnt1, vt[i].cnt);
    end
    start = 0;
    branch_valid = 0;

    // asynchronous reset while holding a valid word
    do_reset();
    start = 1; instr_ready = 0;
    cycle();
    start = 0;
    cycle();
    cycle();
    chk("hold.valid", v1, 1'b1);
    chk("hold.pc", pc1, 8'h02);
    reset = 1'b1;
    #1;
    chk("arst.pc", pc1, 8'h01);
    chk("arst.out", out1, 8'h00);
    chk("arst.ipc", ipc1, 8'h00);
    chk("arst.valid", v1, 1'b0);
    chk("arst.done", d1, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle();
    chk("arst.idle", v1, 1'b0);
    start = 1; instr_ready = 1;
    cycle();
    start = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("restart%0d.out", k), out1, mem[8'(k + 1)]);
      chk($sformatf("restart%0d.ipc", k), ipc1, 8'(k + 1));
    end
    chk("restart.done", d1, 1'b1);

    // wrap-around instance
    do_reset();
    start = 1; instr_ready = 1;
    cycle();
    start = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (v2 && (seen.size() == 0 || seen[$] != ipc2))
        seen.push_back(ipc2);
    end
    chk("wrap.count", seen.size(), 4);
    for (int k = 0; k < seen.size() && k < 4; k++)
      chk($sformatf("wrap%0d.pc", k), seen[k], 8'(8'hFE + k));
    chk("wrap.done", d2, 1'b1);

    // saturation: loop the program via a branch on every DONE
    do_reset();
    start = 1; instr_ready = 1; branch_target = M_RESET;
    cycle();
    start = 0;
    for (int k = 0; k < 450; k++) begin
      branch_valid = m_done();
      cycle();
    end
    branch_valid = 0;
    chk("sat.cnt", cnt1, 8'hFF);
    chk("sat.model", cnt1, m_cnt);

    // random stimulus against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      start = ($urandom_range(0, 9) == 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      branch_valid = ($urandom_range(0, 11) == 0);
      branch_target = ($urandom_range(0, 3) == 0) ?
        8'($urandom) : 8'($urandom_range(0, 4));
      cycle();
      chk($sformatf("rand%0d", k),
          {pc1, out1, ipc1, v1, d1, cnt1},
          {m_pc, m_word, m_wpc, m_valid, m_done(), m_cnt});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
